// File: rtl/wta_pkg.sv
// Shared WTA network defaults and the winner-decoder scan state encoding.
// Pure declarations; no timing behaviour.
package wta_pkg;
    localparam int N_NEURONS = 8;
    localparam int CNT_W     = 8;
    localparam int IDX_W     = $clog2(N_NEURONS);

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } scan_state_t;
endpackage

// File: rtl/wta_spike_counter.sv
// Saturating per-neuron spike counter; clear wins over increment.
// Updates one cycle after an enabled edge; no backpressure, holds when en is low.
module wta_spike_counter
    import wta_pkg::*;
#(
    parameter int CNT_W = wta_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (clear) begin
                cnt <= '0;
            end else if (inc && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/wta_winner_decoder.sv
// Per-window spike tally of the WTA network; reports winner index/count/tie/none.
// Result pulses N_NEURONS+1 edges after the window-closing edge; no backpressure.
module wta_winner_decoder
    import wta_pkg::*;
#(
    parameter int N_NEURONS = wta_pkg::N_NEURONS,
    parameter int CNT_W     = wta_pkg::CNT_W,
    parameter int WINDOW    = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [N_NEURONS-1:0]         spikes,
    output logic [$clog2(N_NEURONS)-1:0] win_idx,
    output logic [CNT_W-1:0]             win_cnt,
    output logic                         win_tie,
    output logic                         win_none,
    output logic                         win_valid
);
    localparam int                  IW       = $clog2(N_NEURONS);
    localparam int                  TMR_W    = $clog2(WINDOW);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(WINDOW - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    logic [TMR_W-1:0] tmr;
    logic             snap_now;
    logic [CNT_W-1:0] live_cnt [N_NEURONS];
    logic [CNT_W-1:0] snap     [N_NEURONS];

    scan_state_t      state, state_nx;
    logic [IW-1:0]    idx, bidx;
    logic [CNT_W-1:0] best;
    logic             tie;

    assign snap_now = en && (tmr == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (en) begin
            tmr <= snap_now ? '0 : tmr + TMR_W'(1);
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cnt
        wta_spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .inc   (spikes[g]),
            .clear (snap_now),
            .cnt   (live_cnt[g])
        );
    end

    // Closing-cycle spikes are folded into the snapshot, not the next window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) snap[i] <= '0;
        end else if (snap_now) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                snap[i] <= (spikes[i] && (live_cnt[i] != CNT_MAX))
                           ? live_cnt[i] + CNT_W'(1) : live_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= COUNT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            COUNT:   if (snap_now) state_nx = SCAN;
            SCAN:    if (idx == IDX_LAST) state_nx = DONE;
            DONE:    state_nx = COUNT;
            default: state_nx = COUNT;
        endcase
    end

    // Strict > keeps the lowest index on equal counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            bidx      <= '0;
            best      <= '0;
            tie       <= 1'b0;
            win_idx   <= '0;
            win_cnt   <= '0;
            win_tie   <= 1'b0;
            win_none  <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            case (state)
                COUNT: begin
                    if (snap_now) begin
                        idx  <= '0;
                        bidx <= '0;
                        best <= '0;
                        tie  <= 1'b0;
                    end
                end
                SCAN: begin
                    idx <= idx + IW'(1);
                    if (snap[idx] > best) begin
                        best <= snap[idx];
                        bidx <= idx;
                        tie  <= 1'b0;
                    end else if ((snap[idx] == best) && (best != '0)) begin
                        tie <= 1'b1;
                    end
                end
                DONE: begin
                    win_idx   <= bidx;
                    win_cnt   <= best;
                    win_tie   <= tie;
                    win_none  <= (best == '0);
                    win_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wta_winner_decoder.sv
// Directed windows against a per-cycle reference tally with a result scoreboard.
module tb_wta_winner_decoder;
    localparam int N    = 8;
    localparam int CW   = 8;
    localparam int WIN  = 256;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        int idx;
        int cnt;
        bit tie;
        bit none;
        int due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  spikes = '0;
    logic [2:0]    win_idx;
    logic [CW-1:0] win_cnt;
    logic          win_tie;
    logic          win_none;
    logic          win_valid;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_cnt [N];
    int   m_tmr = 0;
    exp_t sb [$];

    wta_winner_decoder #(.N_NEURONS(N), .CNT_W(CW), .WINDOW(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spikes    (spikes),
        .win_idx   (win_idx),
        .win_cnt   (win_cnt),
        .win_tie   (win_tie),
        .win_none  (win_none),
        .win_valid (win_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t judge(input int due);
        exp_t e;
        int   nmax;
        e.idx = 0;
        e.cnt = 0;
        nmax  = 0;
        for (int i = 0; i < N; i++) begin
            if (m_cnt[i] > e.cnt) begin
                e.cnt = m_cnt[i];
                e.idx = i;
            end
        end
        for (int i = 0; i < N; i++) if (m_cnt[i] == e.cnt) nmax++;
        e.none = (e.cnt == 0);
        e.tie  = (e.cnt != 0) && (nmax > 1);
        e.due  = due;
        return e;
    endfunction

    // Reference tally: the window closes on its WIN-th enabled cycle and the
    // result is due N+1 edges later.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_tmr = 0;
            sb.delete();
        end else if (en) begin
            for (int i = 0; i < N; i++) if (spikes[i] && m_cnt[i] < MAXC) m_cnt[i]++;
            if (m_tmr == WIN - 1) begin
                sb.push_back(judge(cyc + N + 1));
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                m_tmr = 0;
            end else begin
                m_tmr++;
            end
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("valid_pulse", win_valid, 1);
            check("win_idx", win_idx, e.idx);
            check("win_cnt", win_cnt, e.cnt);
            check("win_tie", win_tie, e.tie);
            check("win_none", win_none, e.none);
        end else begin
            check("no_spurious_valid", win_valid, 0);
        end
    end

    task automatic drive(input logic e, input logic [N-1:0] s);
        en     = e;
        spikes = s;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_idx"}, win_idx, 0);
        check({tag, "_cnt"}, win_cnt, 0);
        check({tag, "_tie"}, win_tie, 0);
        check({tag, "_none"}, win_none, 0);
        check({tag, "_valid"}, win_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Empty window: none reported, and nothing before WINDOW+N cycles.
        for (int k = 0; k < WIN; k++) drive(1'b1, 8'h00);

        // Neuron 5 every cycle saturates at 255.
        for (int k = 0; k < WIN; k++) drive(1'b1, 8'h20);

        // Neurons 2 and 6 tie at 10, others at 3.
        for (int k = 0; k < WIN; k++)
            drive(1'b1, (k < 3) ? 8'hFF : (k < 10) ? 8'h44 : 8'h00);

        // Single spike on the last window cycle.
        for (int k = 0; k < WIN - 1; k++) drive(1'b1, 8'h00);
        drive(1'b1, 8'h02);

        // Fresh window (neuron 1 must restart at 0) with an en-low gap whose spikes are ignored.
        drive(1'b1, 8'h08);
        for (int k = 0; k < 100; k++) drive(1'b1, 8'h00);
        for (int k = 0; k < 50; k++)  drive(1'b0, 8'hFF);
        for (int k = 0; k < WIN - 101; k++) drive(1'b1, 8'h00);

        // Window whose scan is cut short by reset.
        for (int k = 0; k < WIN; k++) drive(1'b1, (k < 5) ? 8'h01 : 8'h00);
        repeat (3) drive(1'b1, 8'h00);
        rst_n = 1'b0;
        repeat (2) drive(1'b0, 8'h00);
        check_outputs_zero("scan_reset");
        rst_n = 1'b1;

        // Post-reset window reports normally: neurons 4 and 7 tie at 20.
        for (int k = 0; k < WIN; k++) drive(1'b1, (k < 20) ? 8'h90 : 8'h00);
        repeat (N + 4) drive(1'b0, 8'h00);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
